apb_stream_master: RTL and testbench
====================================

APB_STREAM_MASTER -- requirements
Module: apb_stream_master

Interface
REQ-001 Parameter TIMEOUT, default 255, is the maximum number of access-phase cycles to wait for PREADY; legal range 1..65535.
REQ-002 PCLK  in  1  sole clock; all logic on the rising edge.
REQ-003 PRESETn  in  1  reset, synchronous, active-low.
REQ-004 cmd_tvalid  in  1  command byte valid.
REQ-005 cmd_tready  out  1  command byte accepted when cmd_tvalid & cmd_tready.
REQ-006 cmd_tdata  in  8  command byte.
REQ-007 rsp_tvalid  out  1  response byte valid.
REQ-008 rsp_tready  in  1  response sink ready.
REQ-009 rsp_tdata  out  8  response byte.
REQ-010 PADDR  out  32  APB address.
REQ-011 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-012 PWDATA  out  32  APB write data.
REQ-013 PSTRB  out  4  fixed at 4'hF on writes and 4'h0 on reads.
REQ-014 PPROT  out  3  fixed at 3'b000.
REQ-015 PRDATA  in  32, PREADY  in  1, PSLVERR  in  1  APB responder returns.

Function
REQ-016 The block SHALL act as a stream-to-APB initiator: byte frames in, one APB transfer per frame, response bytes out.
REQ-017 Frame format: opcode byte (0x01 = write, 0x02 = read), 4 address bytes (LSB first), then 4 data bytes (LSB first) for writes only.
REQ-018 FSM states: IDLE, ADDR, WDATA, SETUP, ACCESS, RESP.
REQ-019 IDLE -> ADDR on an accepted 0x01/0x02; IDLE -> RESP with one status byte 0xEE on any other accepted opcode.
REQ-020 ADDR -> WDATA (write) or SETUP (read) after the 4th address byte is accepted; WDATA -> SETUP after the 4th data byte.
REQ-021 cmd_tready SHALL be 1 only in IDLE, ADDR and WDATA; a byte counter (0..3) advances only on accepted bytes; stalls on cmd_tvalid=0 are unbounded.
REQ-022 SETUP SHALL last exactly 1 cycle: PSEL=1, PENABLE=0, with PADDR, PWRITE and PWDATA valid.
REQ-023 ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE and PWDATA SHALL be held stable; exit when PREADY=1, sampling PRDATA and PSLVERR on that cycle.
REQ-024 ACCESS timeout: if PREADY is still 0 after TIMEOUT consecutive ACCESS cycles, PSEL and PENABLE SHALL drop on the next cycle and status is 0x02.
REQ-025 Status byte: 0x00 OK, 0x01 PSLVERR=1, 0x02 timeout, 0xEE bad opcode.
REQ-026 Read response = status byte then PRDATA as 4 bytes, LSB first (5 bytes); data bytes are sent even on error (captured PRDATA, or 0 on timeout).
REQ-027 Write response and bad-opcode response are the status byte only.
REQ-028 RESP: rsp_tvalid=1, rsp_tdata held stable until rsp_tready=1; advance one byte per handshake; after the last byte, go to IDLE on the next cycle.
REQ-029 Latency: with last command byte accepted at cycle N and PREADY=1 at N+2, SETUP occurs at N+1, ACCESS at N+2, and rsp_tvalid is first 1 at N+3.
REQ-030 PSEL and rsp_tvalid SHALL never both be 1 on the same cycle; cmd_tready SHALL be 0 whenever PSEL=1 or rsp_tvalid=1.
REQ-031 Back-to-back frames: a new opcode SHALL be accepted no earlier than the cycle after the final response handshake.

Reset
REQ-032 When PRESETn=0 at a rising edge: state=IDLE; counters cleared; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, rsp_tvalid=0, rsp_tdata=0; cmd_tready=1 from the first cycle after release.
REQ-033 Reset mid-frame or mid-transfer SHALL abort immediately (PSEL drops that edge) and discard partial bytes and pending response.

Verification
REQ-034 Write 01 10 00 00 40 78 56 34 12, PREADY=1 at once -> PADDR=0x40000010, PWDATA=0x12345678, PWRITE=1, PSTRB=F; response 00.
REQ-035 Read 02 04 00 00 40, PREADY after 3 wait cycles, PRDATA=0xCAFEBABE -> PADDR stable across waits; response 00 BE BA FE CA.
REQ-036 Read with PSLVERR=1, PRDATA=0x11223344 -> response 01 44 33 22 11; bad opcode 0x7F -> response EE and no PSEL activity.
REQ-037 TIMEOUT=4, PREADY held 0 on a write -> PSEL drops after 4 ACCESS cycles; response 02.
REQ-038 Random cmd_tvalid/rsp_tready gaps over 100 mixed frames -> responses match the model, rsp_tdata is stable while stalled, and REQ-030 holds every cycle.
REQ-039 PRESETn=0 during ACCESS -> PSEL=0 the next edge, no response emitted, and the next frame completes normally.

Source files
------------

// File: rtl/apb_stream_master.sv
// Byte-stream to APB initiator: one framed command in, one APB transfer,
// status (and read data) bytes back out on the response stream.
module apb_stream_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_tvalid,
  output logic        cmd_tready,
  input  logic [7:0]  cmd_tdata,
  output logic        rsp_tvalid,
  input  logic        rsp_tready,
  output logic [7:0]  rsp_tdata,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  output logic [2:0]  PPROT,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam logic [7:0]  OP_WR     = 8'h01;
  localparam logic [7:0]  OP_RD     = 8'h02;
  localparam logic [7:0]  ST_OK     = 8'h00;
  localparam logic [7:0]  ST_SLVERR = 8'h01;
  localparam logic [7:0]  ST_TMO    = 8'h02;
  localparam logic [7:0]  ST_BADOP  = 8'hEE;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [39:0] rsp_buf_q, rsp_buf_d;
  logic [2:0]  rsp_left_q, rsp_left_d;

  logic cmd_fire;
  logic rsp_fire;
  logic [2:0] rsp_len;

  assign cmd_tready = (state_q == S_IDLE)
                   || (state_q == S_ADDR)
                   || (state_q == S_WDATA);
  assign rsp_tvalid = (state_q == S_RESP);
  assign rsp_tdata  = rsp_buf_q[7:0];

  assign PSEL    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign PENABLE = (state_q == S_ACCESS);
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PSTRB   = pwrite_q ? 4'hF : 4'h0;
  assign PPROT   = 3'b000;

  assign cmd_fire = cmd_tvalid && cmd_tready;
  assign rsp_fire = rsp_tvalid && rsp_tready;
  assign rsp_len  = pwrite_q ? 3'd1 : 3'd5;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    wait_cnt_d = wait_cnt_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    rsp_buf_d  = rsp_buf_q;
    rsp_left_d = rsp_left_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          byte_cnt_d = 2'd0;
          if (cmd_tdata == OP_WR) begin
            pwrite_d = 1'b1;
            state_d  = S_ADDR;
          end else if (cmd_tdata == OP_RD) begin
            pwrite_d = 1'b0;
            state_d  = S_ADDR;
          end else begin
            rsp_buf_d  = {32'h0, ST_BADOP};
            rsp_left_d = 3'd1;
            state_d    = S_RESP;
          end
        end
      end
      S_ADDR: begin
        if (cmd_fire) begin
          paddr_d    = {cmd_tdata, paddr_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = pwrite_q ? S_WDATA : S_SETUP;
          end
        end
      end
      S_WDATA: begin
        if (cmd_fire) begin
          pwdata_d   = {cmd_tdata, pwdata_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        wait_cnt_d = 16'd0;
        state_d    = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          rsp_buf_d[7:0]  = PSLVERR ? ST_SLVERR : ST_OK;
          rsp_buf_d[39:8] = pwrite_q ? 32'h0 : PRDATA;
          rsp_left_d      = rsp_len;
          state_d         = S_RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Timed-out reads still return four (zero) data bytes
          rsp_buf_d  = {32'h0, ST_TMO};
          rsp_left_d = rsp_len;
          state_d    = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        if (rsp_fire) begin
          rsp_buf_d  = {8'h0, rsp_buf_q[39:8]};
          rsp_left_d = rsp_left_q - 3'd1;
          if (rsp_left_q == 3'd1) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      wait_cnt_q <= 16'd0;
      pwrite_q   <= 1'b0;
      paddr_q    <= 32'h0;
      pwdata_q   <= 32'h0;
      rsp_buf_q  <= 40'h0;
      rsp_left_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      rsp_buf_q  <= rsp_buf_d;
      rsp_left_q <= rsp_left_d;
    end
  end

endmodule

// File: tb/tb_apb_stream_master.sv
// Bench for apb_stream_master: directed frames, timeout, reset abort,
// then randomized frames against a frame-level response model.
module tb_apb_stream_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        PRESETn;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic [7:0]  cmd_tdata;
  logic        rsp_tvalid;
  logic        rsp_tready = 1'b0;
  logic [7:0]  rsp_tdata;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY = 1'b0;
  logic        PSLVERR;

  apb_stream_master #(.TIMEOUT(TO)) dut (
    .PCLK(clk),
    .PRESETn(PRESETn),
    .cmd_tvalid(cmd_tvalid),
    .cmd_tready(cmd_tready),
    .cmd_tdata(cmd_tdata),
    .rsp_tvalid(rsp_tvalid),
    .rsp_tready(rsp_tready),
    .rsp_tdata(rsp_tdata),
    .PADDR(PADDR),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PWRITE(PWRITE),
    .PWDATA(PWDATA),
    .PSTRB(PSTRB),
    .PPROT(PPROT),
    .PRDATA(PRDATA),
    .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  strb;
    int          acc;
  } xfer_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int setup_cyc = 0;
  int first_rsp_cyc = 0;
  int slv_wait = 0;
  bit gaps = 0;
  bit rsp_rand = 0;

  xfer_t       obs_q[$];
  logic [7:0]  rsp_q[$];

  logic [31:0] cur_addr;
  logic        cur_wr;
  logic [31:0] cur_wd;
  logic [3:0]  cur_strb;
  int          acc = 0;
  bit          in_xfer = 0;
  bit          prev_stall = 0;
  bit          prev_valid = 0;
  logic [7:0]  prev_data = 8'h0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // APB responder plus bus monitor
  always @(negedge clk) begin
    if (!PRESETn) begin
      PREADY = 1'b0;
    end else begin
      chk("psel_and_rsp", PSEL && rsp_tvalid, 1'b0);
      chk("tready_busy", cmd_tready && (PSEL || rsp_tvalid), 1'b0);
      chk("pprot", PPROT, 3'b000);
      if (PSEL && !PENABLE) begin
        cur_addr  = PADDR;
        cur_wr    = PWRITE;
        cur_wd    = PWDATA;
        cur_strb  = PSTRB;
        acc       = 0;
        in_xfer   = 1;
        setup_cyc = cyc;
        PREADY    = 1'b0;
      end else if (PSEL && PENABLE) begin
        chk("paddr_stable", PADDR, cur_addr);
        chk("pwrite_stable", PWRITE, cur_wr);
        chk("pwdata_stable", PWDATA, cur_wd);
        PREADY = (acc == slv_wait);
        acc++;
      end else begin
        PREADY = 1'b0;
        if (in_xfer) begin
          obs_q.push_back('{cur_addr, cur_wr, cur_wd, cur_strb, acc});
          in_xfer = 0;
        end
      end
    end
  end

  // Response sink
  always @(negedge clk) begin
    if (!PRESETn) begin
      rsp_tready = 1'b0;
      prev_stall = 0;
      prev_valid = 0;
    end else begin
      if (prev_stall) begin
        chk("rsp_hold_valid", rsp_tvalid, 1'b1);
        chk("rsp_hold_data", rsp_tdata, prev_data);
      end
      if (rsp_tvalid && !prev_valid) first_rsp_cyc = cyc;
      rsp_tready = rsp_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
      if (rsp_tvalid && rsp_tready) rsp_q.push_back(rsp_tdata);
      prev_stall = rsp_tvalid && !rsp_tready;
      prev_valid = rsp_tvalid;
      prev_data  = rsp_tdata;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (gaps && $urandom_range(0, 3) == 0) begin
      cmd_tvalid = 1'b0;
      @(negedge clk);
    end
    cmd_tvalid = 1'b1;
    cmd_tdata  = b;
    while (!cmd_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_tready, 1'b1);
    last_acc_cyc = cyc;
    @(negedge clk);
    cmd_tvalid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int w, input logic err);
    logic [7:0] exp[$];
    logic [7:0] st;
    logic [31:0] rbytes;
    bit is_wr = (op == 8'h01);
    bit is_rd = (op == 8'h02);
    bit tmo = (w >= TO);
    int n = 0;
    xfer_t x;
    slv_wait = w;
    PRDATA   = rd;
    PSLVERR  = err;
    if (!(is_wr || is_rd)) st = 8'hEE;
    else if (tmo) st = 8'h02;
    else if (err) st = 8'h01;
    else st = 8'h00;
    exp.push_back(st);
    if (is_rd) begin
      rbytes = tmo ? 32'h0 : rd;
      for (int i = 0; i < 4; i++) exp.push_back(rbytes[8*i +: 8]);
    end
    send_byte(op);
    if (is_wr || is_rd) begin
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
      if (is_wr) begin
        for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8]);
      end
    end
    while (rsp_q.size() < exp.size() && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("rsp_len", rsp_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rsp_q.size(); i++) begin
      chk($sformatf("rsp_byte%0d", i), rsp_q[i], exp[i]);
    end
    chk("xfer_count", obs_q.size(), (is_wr || is_rd) ? 1 : 0);
    if (obs_q.size() > 0 && (is_wr || is_rd)) begin
      x = obs_q.pop_front();
      chk("paddr", x.addr, addr);
      chk("pwrite", x.wr, is_wr);
      chk("pstrb", x.strb, is_wr ? 4'hF : 4'h0);
      chk("access_cycles", x.acc, tmo ? TO : w + 1);
      if (is_wr) chk("pwdata", x.wd, wd);
    end
    obs_q.delete();
    rsp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] op;
    PRESETn    = 1'b0;
    cmd_tvalid = 1'b0;
    cmd_tdata  = 8'h0;
    PRDATA     = 32'h0;
    PSLVERR    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_pstrb", PSTRB, 4'h0);
    chk("rst_rsp_valid", rsp_tvalid, 1'b0);
    chk("rst_rsp_data", rsp_tdata, 8'h0);
    PRESETn = 1'b1;
    @(negedge clk);
    chk("rst_cmd_tready", cmd_tready, 1'b1);

    run_frame(8'h01, 32'h4000_0010, 32'h1234_5678, 32'h0, 0, 1'b0);
    chk("lat_setup", setup_cyc, last_acc_cyc + 1);
    chk("lat_rsp", first_rsp_cyc, last_acc_cyc + 3);
    run_frame(8'h02, 32'h4000_0004, 32'h0, 32'hCAFE_BABE, 3, 1'b0);
    run_frame(8'h02, 32'h4000_0008, 32'h0, 32'h1122_3344, 0, 1'b1);
    run_frame(8'h7F, 32'h0, 32'h0, 32'h0, 0, 1'b0);
    run_frame(8'h01, 32'h4000_0020, 32'hDEAD_BEEF, 32'h0, 50, 1'b0);
    run_frame(8'h02, 32'h4000_0024, 32'h0, 32'h5555_AAAA, 50, 1'b1);

    // Reset while the transfer is in its access phase
    slv_wait = 100;
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'h30);
    n = 0;
    while (!(PSEL && PENABLE) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reached_access", PSEL && PENABLE, 1'b1);
    PRESETn = 1'b0;
    @(negedge clk);
    chk("abort_psel", PSEL, 1'b0);
    chk("abort_penable", PENABLE, 1'b0);
    chk("abort_rsp_valid", rsp_tvalid, 1'b0);
    PRESETn = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_rsp", rsp_q.size(), 0);
    obs_q.delete();
    rsp_q.delete();
    run_frame(8'h02, 32'h4000_0030, 32'h0, 32'h0BAD_F00D, 1, 1'b0);

    gaps     = 1;
    rsp_rand = 1;
    for (int f = 0; f < 100; f++) begin
      n = $urandom_range(0, 19);
      if (n < 9) op = 8'h01;
      else if (n < 18) op = 8'h02;
      else begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h01 || op == 8'h02) op = 8'hA5;
      end
      run_frame(op, $urandom, $urandom, $urandom,
                $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
